rs_dispatch: RTL and testbench
==============================

RS_DISPATCH -- requirements
Module: rs_dispatch

Interface
REQ-001 SHALL have parameter NUM_ENTRIES, default 4: number of reservation-station entries read (power of two, 2..8).
REQ-002 SHALL have parameter data_width, default 16: operand width.
REQ-003 SHALL have parameter tag_width, default 3: ROB/dest tag width.
REQ-004 SHALL have port clk  input  1: single clock, rising edge.
REQ-005 SHALL have port rst_n  input  1: asynchronous active-low reset.
REQ-006 SHALL have port flush  input  1: synchronous pipeline flush.
REQ-007 SHALL have ports rs_busy, rs_vj_valid, rs_vk_valid  input  [NUM_ENTRIES]: per-entry status.
REQ-008 SHALL have ports rs_vj, rs_vk  input  [NUM_ENTRIES][data_width]: per-entry operands.
REQ-009 SHALL have ports rs_qj, rs_qk, rs_dest  input  [NUM_ENTRIES][tag_width]: per-entry tags.
REQ-010 SHALL have port rs_op  input  [NUM_ENTRIES] lc3b_opcode: per-entry opcode.
REQ-011 SHALL have port rs_clr  output  [NUM_ENTRIES]: one-hot pulse freeing the dispatched entry (drives ld_busy, busy_in=0).
REQ-012 SHALL have ports cdb_valid  input  1, cdb_tag  input  tag_width, cdb_data  input  data_width: result-broadcast snoop.
REQ-013 SHALL have ports fu_valid  output  1, fu_ready  input  1: functional-unit handshake.
REQ-014 SHALL have ports fu_op  output  lc3b_opcode, fu_a, fu_b  output  data_width, fu_dest  output  tag_width: dispatched payload.

Function
REQ-015 Entry i SHALL be ready when rs_busy[i] && rs_vj_valid[i] && rs_vk_valid[i] && !rs_clr_q[i] (entry not freed last cycle).
REQ-016 Output register SHALL accept a new op when !fu_valid || fu_ready ("slot free").
REQ-017 When slot free and any entry ready, SHALL grant one entry by round-robin starting at pointer rr_ptr, searching upward with wrap from NUM_ENTRIES-1 to 0.
REQ-018 On grant of entry g SHALL, same cycle, assert rs_clr[g] combinationally for exactly one cycle, and on the next edge load fu_op/fu_a/fu_b/fu_dest from entry g, set fu_valid=1, set rr_ptr=(g+1) mod NUM_ENTRIES.
REQ-019 Latency: ready entry with free slot SHALL appear on fu_valid at the following clock edge (1 cycle).
REQ-020 While fu_valid && !fu_ready, payload SHALL hold stable, no grant, rs_clr all zero.
REQ-021 fu_valid && fu_ready with another ready entry SHALL grant back-to-back (one dispatch per cycle sustained).
REQ-022 fu_valid && fu_ready with no ready entry SHALL clear fu_valid next edge.
REQ-023 No ready entries: rs_clr=0, rr_ptr unchanged.
REQ-024 flush SHALL clear fu_valid next edge, suppress rs_clr that cycle; rr_ptr unchanged; payload don't-care.
REQ-025 Opcode SHALL pass through unmodified; operand widths unchanged, no arithmetic on data.

Reset
REQ-026 rst_n low SHALL asynchronously force fu_valid=0, rr_ptr=0, rs_clr_q=0, payload registers=0.
REQ-027 rs_clr SHALL be 0 while rst_n low; reset mid-handshake drops the in-flight op without re-dispatch.

Configuration
REQ-028 With RS_DISPATCH_BYPASS_EN defined, an operand whose valid bit is 0 SHALL count valid when cdb_valid && matching tag (rs_qj/rs_qk == cdb_tag), and cdb_data SHALL be used as that operand in the dispatched payload.
REQ-029 Without RS_DISPATCH_BYPASS_EN, cdb_* SHALL be ignored; readiness uses only stored valid bits (wakeup one cycle later via the entry's own CDB load).

Structure
REQ-030 lc3b_opcode and the tag/data width constants SHALL live in lc3b_types; no new package types.
REQ-031 The round-robin priority picker SHALL be a separate sub-module rr_arbiter (request vector, pointer in, one-hot grant + index out, purely combinational).

Verification
REQ-032 Reset: rst_n=0 mid-run with fu_valid=1 -> fu_valid=0, rs_clr=0 immediately; after release first grant from entry 0 scan.
REQ-033 Single ready: entry 2 busy, Vj=0x0005, Vk=0x0003, dest=4, op=ADD, fu_ready=1 -> rs_clr=4'b0100 one cycle; next cycle fu_valid=1, fu_a=5, fu_b=3, fu_dest=4.
REQ-034 Round-robin: all four entries ready, fu_ready=1 -> grants 0,1,2,3 on consecutive cycles, each rs_clr one-hot once.
REQ-035 Backpressure: fu_ready=0 for 3 cycles with entries 1,3 ready -> payload stable, rs_clr=0; fu_ready=1 -> entry 1 dispatches, then entry 3.
REQ-036 Flush: flush=1 while entry 0 ready and slot free -> rs_clr=0, fu_valid=0 next cycle.
REQ-037 Bypass (macro on): entry 1 Vk_valid=0, Qk=6, cdb_valid=1, cdb_tag=6, cdb_data=0x00AA -> entry 1 granted, fu_b=0x00AA; macro off -> no grant that cycle.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b types: opcode encoding plus default tag and data widths
// used by the out-of-order dispatch blocks.
package lc3b_types;

  localparam int DATA_WIDTH = 16;
  localparam int TAG_WIDTH  = 3;

  typedef enum logic [3:0] {
    OP_BR   = 4'b0000,
    OP_ADD  = 4'b0001,
    OP_LDB  = 4'b0010,
    OP_STB  = 4'b0011,
    OP_JSR  = 4'b0100,
    OP_AND  = 4'b0101,
    OP_LDR  = 4'b0110,
    OP_STR  = 4'b0111,
    OP_RTI  = 4'b1000,
    OP_NOT  = 4'b1001,
    OP_LDI  = 4'b1010,
    OP_STI  = 4'b1011,
    OP_JMP  = 4'b1100,
    OP_SHF  = 4'b1101,
    OP_LEA  = 4'b1110,
    OP_TRAP = 4'b1111
  } lc3b_opcode;

endpackage

// File: rtl/rs_dispatch_if.sv
// Dispatch-to-functional-unit handshake: valid/ready plus the issued payload.
interface rs_dispatch_if
  import lc3b_types::*;
#(
  parameter int data_width = DATA_WIDTH,
  parameter int tag_width  = TAG_WIDTH
);

  logic                  fu_valid;
  logic                  fu_ready;
  lc3b_opcode            fu_op;
  logic [data_width-1:0] fu_a;
  logic [data_width-1:0] fu_b;
  logic [tag_width-1:0]  fu_dest;

  modport master (output fu_valid, fu_op, fu_a, fu_b, fu_dest, input fu_ready);
  modport slave  (input fu_valid, fu_op, fu_a, fu_b, fu_dest, output fu_ready);

endinterface

// File: rtl/rs_dispatch_rr_arbiter.sv
// Combinational round-robin picker: first request at or above ptr_i, wrapping
// past the top, reported as a one-hot grant and a binary index.
module rr_arbiter #(
  parameter int N    = 4,
  parameter int IDXW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [IDXW-1:0] ptr_i,
  output logic [N-1:0]    grant_o,
  output logic [IDXW-1:0] idx_o,
  output logic            any_o
);

  logic found;
  int   j;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    j       = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr_i) + k) % N;
      if (!found && req_i[j]) begin
        found      = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = IDXW'(j);
      end
    end
  end

  assign any_o = found;

endmodule

// File: rtl/rs_dispatch.sv
// Reservation-station dispatch: picks one ready entry per cycle round-robin and
// registers it toward the functional unit. Define RS_DISPATCH_BYPASS_EN to wake operands off the CDB.
module rs_dispatch
  import lc3b_types::*;
#(
  parameter int NUM_ENTRIES = 4,
  parameter int data_width  = DATA_WIDTH,
  parameter int tag_width   = TAG_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic [NUM_ENTRIES-1:0] rs_busy,
  input  logic [NUM_ENTRIES-1:0] rs_vj_valid,
  input  logic [NUM_ENTRIES-1:0] rs_vk_valid,
  input  logic [data_width-1:0]  rs_vj   [NUM_ENTRIES],
  input  logic [data_width-1:0]  rs_vk   [NUM_ENTRIES],
  input  logic [tag_width-1:0]   rs_qj   [NUM_ENTRIES],
  input  logic [tag_width-1:0]   rs_qk   [NUM_ENTRIES],
  input  logic [tag_width-1:0]   rs_dest [NUM_ENTRIES],
  input  lc3b_opcode             rs_op   [NUM_ENTRIES],
  output logic [NUM_ENTRIES-1:0] rs_clr,
  input  logic                   cdb_valid,
  input  logic [tag_width-1:0]   cdb_tag,
  input  logic [data_width-1:0]  cdb_data,
  rs_dispatch_if.master          fu
);

  localparam int IDXW = $clog2(NUM_ENTRIES);

  logic [NUM_ENTRIES-1:0] ready;
  logic [NUM_ENTRIES-1:0] vjOk;
  logic [NUM_ENTRIES-1:0] vkOk;
  logic [data_width-1:0]  opA [NUM_ENTRIES];
  logic [data_width-1:0]  opB [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] grantOneHot;
  logic [IDXW-1:0]        grantIdx;
  logic                   grantAny;
  logic                   slotFree;
  logic                   grantEn;

  logic [IDXW-1:0]        rr_ptr_q;
  logic [NUM_ENTRIES-1:0] rs_clr_q;
  logic                   fu_valid_q;
  lc3b_opcode             fu_op_q;
  logic [data_width-1:0]  fu_a_q;
  logic [data_width-1:0]  fu_b_q;
  logic [tag_width-1:0]   fu_dest_q;

  // An entry freed last cycle still looks busy until the station sees rs_clr,
  // so rs_clr_q masks it to prevent a double dispatch.
  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
`ifdef RS_DISPATCH_BYPASS_EN
      vjOk[i] = rs_vj_valid[i] || (cdb_valid && (rs_qj[i] == cdb_tag));
      vkOk[i] = rs_vk_valid[i] || (cdb_valid && (rs_qk[i] == cdb_tag));
      opA[i]  = rs_vj_valid[i] ? rs_vj[i] : cdb_data;
      opB[i]  = rs_vk_valid[i] ? rs_vk[i] : cdb_data;
`else
      vjOk[i] = rs_vj_valid[i];
      vkOk[i] = rs_vk_valid[i];
      opA[i]  = rs_vj[i];
      opB[i]  = rs_vk[i];
`endif
      ready[i] = rs_busy[i] && vjOk[i] && vkOk[i] && !rs_clr_q[i];
    end
  end

`ifndef RS_DISPATCH_BYPASS_EN
  logic unused_cdb;
  always_comb begin
    unused_cdb = ^{cdb_valid, cdb_tag, cdb_data};
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      unused_cdb = unused_cdb ^ (^{rs_qj[i], rs_qk[i]});
    end
  end
`endif

  rr_arbiter #(
    .N    (NUM_ENTRIES),
    .IDXW (IDXW)
  ) u_arb (
    .req_i   (ready),
    .ptr_i   (rr_ptr_q),
    .grant_o (grantOneHot),
    .idx_o   (grantIdx),
    .any_o   (grantAny)
  );

  // rst_n gates the grant so rs_clr stays quiet for the whole reset window.
  assign slotFree = !fu_valid_q || fu.fu_ready;
  assign grantEn  = rst_n && !flush && slotFree && grantAny;
  assign rs_clr   = grantEn ? grantOneHot : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q   <= '0;
      rs_clr_q   <= '0;
      fu_valid_q <= 1'b0;
      fu_op_q    <= lc3b_opcode'(4'b0000);
      fu_a_q     <= '0;
      fu_b_q     <= '0;
      fu_dest_q  <= '0;
    end else begin
      rs_clr_q <= rs_clr;
      if (flush) begin
        fu_valid_q <= 1'b0;
      end else if (grantEn) begin
        fu_valid_q <= 1'b1;
        fu_op_q    <= rs_op[grantIdx];
        fu_a_q     <= opA[grantIdx];
        fu_b_q     <= opB[grantIdx];
        fu_dest_q  <= rs_dest[grantIdx];
        rr_ptr_q   <= grantIdx + IDXW'(1);
      end else if (fu.fu_ready) begin
        fu_valid_q <= 1'b0;
      end
    end
  end

  assign fu.fu_valid = fu_valid_q;
  assign fu.fu_op    = fu_op_q;
  assign fu.fu_a     = fu_a_q;
  assign fu.fu_b     = fu_b_q;
  assign fu.fu_dest  = fu_dest_q;

endmodule

// File: tb/tb_rs_dispatch.sv
// Self-checking bench for rs_dispatch: a queue holds the payloads expected on the
// functional-unit side in order, and every accepted transfer is popped and compared.
module tb_rs_dispatch;
  import lc3b_types::*;

  typedef struct packed {
    lc3b_opcode  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  dest;
  } dispT;

  logic        clk = 1'b0;
  logic        rstN;
  logic        flush;
  logic [3:0]  busy;
  logic [3:0]  vjValid;
  logic [3:0]  vkValid;
  logic [15:0] vj   [4];
  logic [15:0] vk   [4];
  logic [2:0]  qj   [4];
  logic [2:0]  qk   [4];
  logic [2:0]  dest [4];
  lc3b_opcode  op   [4];
  logic [3:0]  rsClr;
  logic        cdbValid;
  logic [2:0]  cdbTag;
  logic [15:0] cdbData;

  int   compareCount  = 0;
  int   mismatchCount = 0;
  dispT sb[$];

  rs_dispatch_if #(.data_width(16), .tag_width(3)) fuIf ();

  rs_dispatch #(
    .NUM_ENTRIES (4),
    .data_width  (16),
    .tag_width   (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rstN),
    .flush       (flush),
    .rs_busy     (busy),
    .rs_vj_valid (vjValid),
    .rs_vk_valid (vkValid),
    .rs_vj       (vj),
    .rs_vk       (vk),
    .rs_qj       (qj),
    .rs_qk       (qk),
    .rs_dest     (dest),
    .rs_op       (op),
    .rs_clr      (rsClr),
    .cdb_valid   (cdbValid),
    .cdb_tag     (cdbTag),
    .cdb_data    (cdbData),
    .fu          (fuIf)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compareCount++;
    if (obs !== exp) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Load one station entry with both operands present.
  task automatic applyStimulus(input int idx, input lc3b_opcode o, input logic [15:0] a,
                               input logic [15:0] b, input logic [2:0] d);
    busy[idx]    = 1'b1;
    vjValid[idx] = 1'b1;
    vkValid[idx] = 1'b1;
    vj[idx]      = a;
    vk[idx]      = b;
    qj[idx]      = 3'd0;
    qk[idx]      = 3'd0;
    dest[idx]    = d;
    op[idx]      = o;
  endtask

  task automatic expectDispatch(input lc3b_opcode o, input logic [15:0] a,
                                input logic [15:0] b, input logic [2:0] d);
    dispT e;
    e.op   = o;
    e.a    = a;
    e.b    = b;
    e.dest = d;
    sb.push_back(e);
  endtask

  // One clock: check rs_clr mid-cycle, pop the scoreboard on an accepted transfer,
  // then let the modelled station drop entries that were freed.
  task automatic tick(input logic [3:0] expClr, input string tag);
    logic [3:0] clrSeen;
    dispT       e;
    @(negedge clk);
    clrSeen = rsClr;
    checkOutput(tag, 32'(rsClr), 32'(expClr));
    if (rstN && fuIf.fu_valid && fuIf.fu_ready) begin
      if (sb.size() == 0) begin
        checkOutput("sbUnderflow", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        checkOutput("fuOp",   32'(fuIf.fu_op),   32'(e.op));
        checkOutput("fuA",    32'(fuIf.fu_a),    32'(e.a));
        checkOutput("fuB",    32'(fuIf.fu_b),    32'(e.b));
        checkOutput("fuDest", 32'(fuIf.fu_dest), 32'(e.dest));
      end
    end
    @(posedge clk);
    #1;
    busy = busy & ~clrSeen;
  endtask

  initial begin
    lc3b_opcode rrOps [4];
    rrOps = '{OP_ADD, OP_AND, OP_NOT, OP_SHF};

    rstN          = 1'b0;
    flush         = 1'b0;
    busy          = '0;
    vjValid       = '0;
    vkValid       = '0;
    cdbValid      = 1'b0;
    cdbTag        = '0;
    cdbData       = '0;
    fuIf.fu_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vj[i] = '0; vk[i] = '0; qj[i] = '0; qk[i] = '0; dest[i] = '0; op[i] = OP_BR;
    end

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstValid", 32'(fuIf.fu_valid), 32'd0);
    checkOutput("rstClr",   32'(rsClr),         32'd0);
    rstN = 1'b1;

    $display("[TB] round-robin over four ready entries");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(i, rrOps[i], 16'h1000 + 16'(i), 16'h2000 + 16'(i), 3'(i + 1));
      expectDispatch(rrOps[i], 16'h1000 + 16'(i), 16'h2000 + 16'(i), 3'(i + 1));
    end
    for (int i = 0; i < 4; i++) tick(4'(1 << i), "clrRr");
    tick(4'b0000, "clrRrDrain");
    checkOutput("validRrDrain", 32'(fuIf.fu_valid), 32'd0);

    $display("[TB] backpressure with entries 1 and 3 ready");
    fuIf.fu_ready = 1'b0;
    applyStimulus(1, OP_LDR, 16'h0111, 16'h0222, 3'd5);
    applyStimulus(3, OP_STR, 16'h0333, 16'h0444, 3'd6);
    expectDispatch(OP_LDR, 16'h0111, 16'h0222, 3'd5);
    expectDispatch(OP_STR, 16'h0333, 16'h0444, 3'd6);
    tick(4'b0010, "clrBpGrant");
    for (int i = 0; i < 3; i++) begin
      tick(4'b0000, "clrBpHold");
      checkOutput("bpHoldA",     32'(fuIf.fu_a),     32'h0111);
      checkOutput("bpHoldValid", 32'(fuIf.fu_valid), 32'd1);
    end
    fuIf.fu_ready = 1'b1;
    tick(4'b1000, "clrBpNext");
    tick(4'b0000, "clrBpDrain");

    $display("[TB] single ready entry then flush");
    applyStimulus(2, OP_ADD, 16'h0005, 16'h0003, 3'd4);
    expectDispatch(OP_ADD, 16'h0005, 16'h0003, 3'd4);
    tick(4'b0100, "clrSingle");
    checkOutput("singleValid", 32'(fuIf.fu_valid), 32'd1);
    checkOutput("singleA",     32'(fuIf.fu_a),     32'h0005);
    checkOutput("singleB",     32'(fuIf.fu_b),     32'h0003);
    checkOutput("singleDest",  32'(fuIf.fu_dest),  32'd4);
    applyStimulus(0, OP_JMP, 16'h0BEE, 16'h0CAB, 3'd7);
    flush = 1'b1;
    tick(4'b0000, "clrFlush");
    checkOutput("validFlush", 32'(fuIf.fu_valid), 32'd0);
    flush = 1'b0;
    expectDispatch(OP_JMP, 16'h0BEE, 16'h0CAB, 3'd7);
    tick(4'b0001, "clrWrap");
    tick(4'b0000, "clrIdle");
    checkOutput("validDrain", 32'(fuIf.fu_valid), 32'd0);

    $display("[TB] CDB snoop on entry 1");
    applyStimulus(1, OP_AND, 16'h0F0F, 16'h0000, 3'd2);
    vkValid[1] = 1'b0;
    qk[1]      = 3'd6;
    cdbValid   = 1'b1;
    cdbTag     = 3'd6;
    cdbData    = 16'h00AA;
`ifdef RS_DISPATCH_BYPASS_EN
    expectDispatch(OP_AND, 16'h0F0F, 16'h00AA, 3'd2);
    tick(4'b0010, "clrBypass");
    cdbValid = 1'b0;
    tick(4'b0000, "clrBypassDrain");
`else
    tick(4'b0000, "clrNoBypass");
    checkOutput("validNoBypass", 32'(fuIf.fu_valid), 32'd0);
    cdbValid = 1'b0;
    busy[1]  = 1'b0;
    tick(4'b0000, "clrNoBypassIdle");
`endif

    $display("[TB] reset during a stalled handshake");
    fuIf.fu_ready = 1'b0;
    applyStimulus(1, OP_LEA, 16'h0DAD, 16'h0FED, 3'd3);
    tick(4'b0010, "clrPreRst");
    checkOutput("validPreRst", 32'(fuIf.fu_valid), 32'd1);
    applyStimulus(1, OP_STB, 16'h0A01, 16'h0B01, 3'd1);
    applyStimulus(3, OP_LDB, 16'h0A03, 16'h0B03, 3'd3);
    #3;
    rstN = 1'b0;
    #1;
    checkOutput("midRstValid", 32'(fuIf.fu_valid), 32'd0);
    checkOutput("midRstClr",   32'(rsClr),         32'd0);
    checkOutput("midRstA",     32'(fuIf.fu_a),     32'd0);
    @(posedge clk);
    #1;
    rstN          = 1'b1;
    fuIf.fu_ready = 1'b1;
    expectDispatch(OP_STB, 16'h0A01, 16'h0B01, 3'd1);
    expectDispatch(OP_LDB, 16'h0A03, 16'h0B03, 3'd3);
    tick(4'b0010, "clrPostRst1");
    tick(4'b1000, "clrPostRst3");
    tick(4'b0000, "clrPostRstDrain");

    checkOutput("sbLeftover", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
